// File: rtl/regfile_ctrl_if.sv
// regfile_ctrl_if: CPU writeback, operand fetch, debug and RAM-side signals of the register-file controller
interface regfile_ctrl_if #(
  parameter int data_bit = 32,
  parameter int adr_bit = 5
);
  logic busy;
  logic wb_req;
  logic [adr_bit-1:0] wb_addr;
  logic [data_bit-1:0] wb_data;
  logic rd_req;
  logic rd_ready;
  logic [adr_bit-1:0] rd_addr_a;
  logic [adr_bit-1:0] rd_addr_b;
  logic rd_valid;
  logic [data_bit-1:0] rd_data_a;
  logic [data_bit-1:0] rd_data_b;
  logic dbg_req;
  logic dbg_we;
  logic [adr_bit-1:0] dbg_addr;
  logic [data_bit-1:0] dbg_wdata;
  logic dbg_ack;
  logic [data_bit-1:0] dbg_rdata;
  logic ram_we;
  logic [adr_bit-1:0] ram_addrw;
  logic [adr_bit-1:0] ram_addrr;
  logic [data_bit-1:0] ram_di;
  logic [data_bit-1:0] ram_dor;
  modport master (
    input busy, rd_ready, rd_valid, rd_data_a, rd_data_b, dbg_ack, dbg_rdata,
    input ram_we, ram_addrw, ram_addrr, ram_di,
    output wb_req, wb_addr, wb_data, rd_req, rd_addr_a, rd_addr_b,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, ram_dor
  );
  modport slave (
    output busy, rd_ready, rd_valid, rd_data_a, rd_data_b, dbg_ack, dbg_rdata,
    output ram_we, ram_addrw, ram_addrr, ram_di,
    input wb_req, wb_addr, wb_data, rd_req, rd_addr_a, rd_addr_b,
    input dbg_req, dbg_we, dbg_addr, dbg_wdata, ram_dor
  );
endinterface

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: zero-fills the register-file RAM after reset, then arbitrates its write port and sequences its read port
module regfile_ctrl #(
  parameter int data_bit = 32,
  parameter int adr_bit = 5
) (
  input logic clk,
  input logic rst,
  regfile_ctrl_if.slave bus
);
  typedef enum logic {CLEAR, RUN} top_t;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, DONE, DBG_RD} seq_t;
  top_t r_top;
  seq_t r_seq;
  logic [adr_bit-1:0] r_clr, r_ram_addrw, r_ram_addrr, r_addr_b;
  logic [data_bit-1:0] r_ram_di, r_tmp_a, r_rd_data_a, r_rd_data_b, r_dbg_rdata;
  logic r_busy, r_rd_ready, r_rd_valid, r_dbg_ack, r_ram_we;
  logic w_run, w_wb, w_dbg_wr, w_rd_go, w_dbg_rd;
  logic [data_bit-1:0] w_cap;
  assign w_run = r_top == RUN && !r_busy;
  assign w_wb = w_run && bus.wb_req;
  assign w_dbg_wr = w_run && bus.dbg_req && bus.dbg_we && !bus.wb_req;
  assign w_rd_go = r_rd_ready && bus.rd_req;
  assign w_dbg_rd = r_rd_ready && !bus.rd_req && bus.dbg_req && !bus.dbg_we;
  // the RAM commits the pending write only at the end of this cycle, so bypass its stale output
  assign w_cap = (r_ram_we && r_ram_addrw == r_ram_addrr) ? r_ram_di : bus.ram_dor;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top <= CLEAR;
      r_seq <= IDLE;
      r_clr <= '0;
      r_busy <= 1'b1;
      r_rd_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_dbg_ack <= 1'b0;
      r_ram_we <= 1'b0;
      r_ram_addrw <= '0;
      r_ram_addrr <= '0;
      r_addr_b <= '0;
      r_ram_di <= '0;
      r_tmp_a <= '0;
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_dbg_ack <= w_dbg_wr;
      r_ram_we <= 1'b0;
      r_rd_ready <= r_top == RUN && (r_seq == DONE || (r_seq == IDLE && !w_rd_go && !w_dbg_rd));
      if (r_top == CLEAR) begin
        r_ram_we <= 1'b1;
        r_ram_addrw <= r_clr;
        r_ram_di <= '0;
        r_clr <= r_clr + 1'b1;
        if (&r_clr) r_top <= RUN;
      end else begin
        r_busy <= 1'b0;
        if (w_wb) begin
          r_ram_we <= |bus.wb_addr;
          r_ram_addrw <= bus.wb_addr;
          r_ram_di <= bus.wb_data;
        end else if (w_dbg_wr) begin
          r_ram_we <= |bus.dbg_addr;
          r_ram_addrw <= bus.dbg_addr;
          r_ram_di <= bus.dbg_wdata;
        end
      end
      case (r_seq)
        IDLE: begin
          if (w_rd_go) begin
            r_seq <= RD_A;
            r_ram_addrr <= bus.rd_addr_a;
            r_addr_b <= bus.rd_addr_b;
          end else if (w_dbg_rd) begin
            r_seq <= DBG_RD;
            r_ram_addrr <= bus.dbg_addr;
          end
        end
        RD_A: begin
          r_tmp_a <= w_cap;
          r_ram_addrr <= r_addr_b;
          r_seq <= RD_B;
        end
        RD_B: begin
          r_rd_data_a <= r_tmp_a;
          r_rd_data_b <= w_cap;
          r_rd_valid <= 1'b1;
          r_seq <= DONE;
        end
        DBG_RD: begin
          r_dbg_rdata <= w_cap;
          r_dbg_ack <= 1'b1;
          r_seq <= DONE;
        end
        default: r_seq <= IDLE;
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.rd_ready = r_rd_ready;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data_a = r_rd_data_a;
  assign bus.rd_data_b = r_rd_data_b;
  assign bus.dbg_ack = r_dbg_ack;
  assign bus.dbg_rdata = r_dbg_rdata;
  assign bus.ram_we = r_ram_we;
  assign bus.ram_addrw = r_ram_addrw;
  assign bus.ram_addrr = r_ram_addrr;
  assign bus.ram_di = r_ram_di;
endmodule
